// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: instruction-memory read port, IF/ID valid/ready output,
// redirect request from EX and the halted status flag.
interface fetch_pc_unit_if;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;

  modport master (
    output pc_out,
    input  instr_in,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_pc_plus4,
    output out_instr,
    input  redirect_valid,
    input  redirect_target,
    output halted
  );

  modport slave (
    input  pc_out,
    output instr_in,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_pc_plus4,
    input  out_instr,
    output redirect_valid,
    output redirect_target,
    input  halted
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, captures {PC, instruction} into a
// valid/ready IF/ID register, and handles stall, redirect/flush and HALT.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic            clock,
  input  logic            reset,
  fetch_pc_unit_if.master bus
);

  localparam logic [31:0] PC_SPAN       = MEM_DEPTH * 4;
  localparam logic [31:0] RESET_PC_WRAP = RESET_PC % PC_SPAN;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] plus4_q, plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_inc;
  logic [31:0] next_pc;
  logic [31:0] redirect_aligned;
  logic [31:0] redirect_pc;
  logic        slot_free;
  logic        transfer;

  // pc_q is always kept below PC_SPAN, so one conditional subtract wraps it.
  always_comb begin
    pc_inc           = pc_q + 32'd4;
    next_pc          = (pc_inc >= PC_SPAN) ? (pc_inc - PC_SPAN) : pc_inc;
    redirect_aligned = bus.redirect_target & ~32'd3;
    redirect_pc      = redirect_aligned % PC_SPAN;
    slot_free        = !valid_q || bus.out_ready;
    transfer         = valid_q && bus.out_ready;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    out_pc_d = out_pc_q;
    plus4_d  = plus4_q;
    instr_d  = instr_q;
    halted_d = halted_q;

    if (bus.redirect_valid) begin
      pc_d     = redirect_pc;
      valid_d  = 1'b0;
      state_d  = ST_RUN;
      halted_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (slot_free) begin
            out_pc_d = pc_q;
            instr_d  = bus.instr_in;
            plus4_d  = next_pc;
            valid_d  = 1'b1;
            pc_d     = next_pc;
            if (bus.instr_in == HALT_INSTR) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (transfer) begin
            valid_d  = 1'b0;
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end
        end
        ST_HALTED: begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC_WRAP;
      valid_q  <= 1'b0;
      out_pc_q <= 32'd0;
      plus4_q  <= 32'd0;
      instr_q  <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      out_pc_q <= out_pc_d;
      plus4_q  <= plus4_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_pc_plus4 = plus4_q;
  assign bus.out_instr    = instr_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios followed by randomized traffic
// checked by a stream-level scoreboard of the expected fetch sequence.
module tb_fetch_pc_unit;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] SPAN  = 32'd1024;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem [DEPTH];
  int          total = 0;
  int          bad   = 0;

  logic [31:0] exp_next;
  logic        stream_open;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC   (32'h0000_0000),
    .MEM_DEPTH  (DEPTH),
    .HALT_INSTR (HALT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  assign bus.instr_in = mem[bus.pc_out[9:2]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt);
    reset               = rst;
    bus.out_ready       = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] wrapPc(input logic [31:0] a);
    logic [31:0] aligned;
    aligned = {a[31:2], 2'b00};
    return aligned % SPAN;
  endfunction

  function automatic logic [31:0] bit32(input logic b);
    return {31'd0, b};
  endfunction

  initial begin
    logic        pre_valid;
    logic [31:0] pre_pc;
    logic [31:0] pre_instr;
    logic [31:0] pre_plus4;
    logic        pre_draining;
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;

    reset               = 1'b1;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0BAD_0000 + 32'(i);
    @(negedge clock);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("reset_fetch", bus.pc_out, 32'd0);
    checkOutput("reset_valid", bit32(bus.out_valid), 32'd0);
    checkOutput("reset_out_pc", bus.out_pc, 32'd0);
    checkOutput("reset_plus4", bus.out_pc_plus4, 32'd0);
    checkOutput("reset_instr", bus.out_instr, 32'd0);
    checkOutput("reset_halted", bit32(bus.halted), 32'd0);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("line_valid", bit32(bus.out_valid), 32'd1);
      checkOutput("line_pc", bus.out_pc, 32'(4 * k));
      checkOutput("line_instr", bus.out_instr, mem[k]);
      checkOutput("line_plus4", bus.out_pc_plus4, 32'(4 * k + 4));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("stall_valid", bit32(bus.out_valid), 32'd1);
      checkOutput("stall_pc", bus.out_pc, 32'd8);
      checkOutput("stall_instr", bus.out_instr, mem[2]);
      checkOutput("stall_fetch", bus.pc_out, 32'd12);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("release_pc", bus.out_pc, 32'd12);
    checkOutput("release_instr", bus.out_instr, mem[3]);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("release_next", bus.out_pc, 32'd16);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("redir_pre_pc", bus.out_pc, 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    checkOutput("redir_valid", bit32(bus.out_valid), 32'd0);
    checkOutput("redir_fetch", bus.pc_out, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("redir_pc", bus.out_pc, 32'h40);
    checkOutput("redir_instr", bus.out_instr, mem[16]);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_03FC);
    checkOutput("wrap_fetch", bus.pc_out, 32'h3FC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("wrap_pc_top", bus.out_pc, 32'h3FC);
    checkOutput("wrap_plus4", bus.out_pc_plus4, 32'd0);
    checkOutput("wrap_instr", bus.out_instr, mem[255]);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("wrap_pc_zero", bus.out_pc, 32'd0);
    checkOutput("wrap_instr0", bus.out_instr, mem[0]);

    mem[2] = HALT;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("halt_capture", bus.out_instr, HALT);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("drain_valid", bit32(bus.out_valid), 32'd1);
      checkOutput("drain_pc", bus.out_pc, 32'd8);
      checkOutput("drain_fetch", bus.pc_out, 32'd12);
      checkOutput("drain_halted", bit32(bus.halted), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("halt_flag", bit32(bus.halted), 32'd1);
    checkOutput("halt_valid", bit32(bus.out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("halt_hold_flag", bit32(bus.halted), 32'd1);
    checkOutput("halt_hold_fetch", bus.pc_out, 32'd12);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd0);
    checkOutput("unhalt_flag", bit32(bus.halted), 32'd0);
    checkOutput("unhalt_fetch", bus.pc_out, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("unhalt_valid", bit32(bus.out_valid), 32'd1);
    checkOutput("unhalt_pc", bus.out_pc, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("prio_drain", bus.out_instr, HALT);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    checkOutput("prio_fetch", bus.pc_out, 32'd0);
    checkOutput("prio_valid", bit32(bus.out_valid), 32'd0);
    checkOutput("prio_halted", bit32(bus.halted), 32'd0);

    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = 32'd0;
      if ($urandom_range(0, 11) == 0) mem[i] = HALT;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    exp_next    = 32'd0;
    stream_open = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      pre_valid    = bus.out_valid;
      pre_pc       = bus.out_pc;
      pre_instr    = bus.out_instr;
      pre_plus4    = bus.out_pc_plus4;
      pre_draining = pre_valid && (pre_instr == HALT);
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = stream_open ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
      tgt = $urandom;
      applyStimulus(rst, rdy, rv, tgt);

      if (rst) begin
        checkOutput("rnd_rst_fetch", bus.pc_out, 32'd0);
        checkOutput("rnd_rst_valid", bit32(bus.out_valid), 32'd0);
        checkOutput("rnd_rst_halted", bit32(bus.halted), 32'd0);
        exp_next    = 32'd0;
        stream_open = 1'b1;
      end else if (rv) begin
        checkOutput("rnd_redir_valid", bit32(bus.out_valid), 32'd0);
        checkOutput("rnd_redir_fetch", bus.pc_out, wrapPc(tgt));
        checkOutput("rnd_redir_halted", bit32(bus.halted), 32'd0);
        exp_next    = wrapPc(tgt);
        stream_open = 1'b1;
      end else if (pre_valid && !rdy) begin
        checkOutput("rnd_hold_valid", bit32(bus.out_valid), 32'd1);
        checkOutput("rnd_hold_pc", bus.out_pc, pre_pc);
        checkOutput("rnd_hold_instr", bus.out_instr, pre_instr);
        checkOutput("rnd_hold_plus4", bus.out_pc_plus4, pre_plus4);
      end else if (!stream_open) begin
        checkOutput("rnd_idle_valid", bit32(bus.out_valid), 32'd0);
        checkOutput("rnd_idle_halted", bit32(bus.halted), 32'd1);
      end else if (pre_draining) begin
        checkOutput("rnd_halt_valid", bit32(bus.out_valid), 32'd0);
        checkOutput("rnd_halt_flag", bit32(bus.halted), 32'd1);
        stream_open = 1'b0;
      end else begin
        checkOutput("rnd_new_valid", bit32(bus.out_valid), 32'd1);
        checkOutput("rnd_new_pc", bus.out_pc, exp_next);
        checkOutput("rnd_new_instr", bus.out_instr, mem[exp_next[9:2]]);
        checkOutput("rnd_new_plus4", bus.out_pc_plus4, (exp_next + 32'd4) % SPAN);
        checkOutput("rnd_new_fetch", bus.pc_out, (exp_next + 32'd4) % SPAN);
        exp_next = (exp_next + 32'd4) % SPAN;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
